// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: resolves the branch decision,
// runs a variable-latency request/acknowledge data-memory access and
// registers the MEM/WB bundle for write-back.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_regWrite_ex_mem,
    input  logic        ctrl_memToReg_ex_mem,
    input  logic        ctrl_branch_ex_mem,
    input  logic        ctrl_memRead_ex_mem,
    input  logic        ctrl_memWrite_ex_mem,
    input  logic        zero_ex_mem,
    input  logic [31:0] branch_or_not_address_ex_mem,
    input  logic [31:0] alu_result_ex_mem,
    input  logic [31:0] read_data_2_ex_mem,
    input  logic [4:0]  write_register_ex_mem,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        ctrl_regWrite_mem_wb,
    output logic        ctrl_memToReg_mem_wb,
    output logic [31:0] read_data_mem_wb,
    output logic [31:0] alu_result_mem_wb,
    output logic [4:0]  write_register_mem_wb,
    output logic        mem_fault,
    output logic        bus_error
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  count_r;
    logic [31:0]    cap_data_r;
    logic           err_r;

    logic           mem_op_s;
    logic           misaligned_s;
    logic           stall_s;

    assign mem_op_s      = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    assign misaligned_s  = mem_op_s & (alu_result_ex_mem[1:0] != 2'b00);
    assign stall         = stall_s;
    assign pc_src        = ctrl_branch_ex_mem & zero_ex_mem & ~stall_s;
    assign branch_target = branch_or_not_address_ex_mem;

    // Hold the front of the pipeline from the issue cycle until the ack/timeout.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_op_s && !misaligned_s) begin
                    stall_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            S_WAIT:  stall_s = 1'b1;
            S_DONE:  stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM together with the memory port and MEM/WB registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r               <= S_IDLE;
            count_r               <= {CW{1'b0}};
            cap_data_r            <= 32'd0;
            err_r                 <= 1'b0;
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            dmem_addr             <= 32'd0;
            dmem_wdata            <= 32'd0;
            ctrl_regWrite_mem_wb  <= 1'b0;
            ctrl_memToReg_mem_wb  <= 1'b0;
            read_data_mem_wb      <= 32'd0;
            alu_result_mem_wb     <= 32'd0;
            write_register_mem_wb <= 5'd0;
            mem_fault             <= 1'b0;
            bus_error             <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            bus_error <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (misaligned_s) begin
                        // Drop the instruction: bubble into MEM/WB, no request.
                        ctrl_regWrite_mem_wb <= 1'b0;
                        ctrl_memToReg_mem_wb <= 1'b0;
                        read_data_mem_wb     <= 32'd0;
                        mem_fault            <= 1'b1;
                    end else if (mem_op_s) begin
                        dmem_addr            <= alu_result_ex_mem;
                        dmem_wdata           <= read_data_2_ex_mem;
                        dmem_we              <= ctrl_memWrite_ex_mem;
                        dmem_req             <= 1'b1;
                        count_r              <= {CW{1'b0}};
                        ctrl_regWrite_mem_wb <= 1'b0;
                        ctrl_memToReg_mem_wb <= 1'b0;
                        read_data_mem_wb     <= 32'd0;
                        state_r              <= S_WAIT;
                    end else begin
                        ctrl_regWrite_mem_wb  <= ctrl_regWrite_ex_mem;
                        ctrl_memToReg_mem_wb  <= ctrl_memToReg_ex_mem;
                        read_data_mem_wb      <= 32'd0;
                        alu_result_mem_wb     <= alu_result_ex_mem;
                        write_register_mem_wb <= write_register_ex_mem;
                    end
                end
                S_WAIT: begin
                    ctrl_regWrite_mem_wb <= 1'b0;
                    ctrl_memToReg_mem_wb <= 1'b0;
                    if (dmem_ack) begin
                        // Ack takes priority over a coincident timeout.
                        cap_data_r <= dmem_we ? 32'd0 : dmem_rdata;
                        dmem_req   <= 1'b0;
                        state_r    <= S_DONE;
                    end else if (count_r == LAST_COUNT) begin
                        cap_data_r <= 32'd0;
                        dmem_req   <= 1'b0;
                        bus_error  <= 1'b1;
                        err_r      <= 1'b1;
                        state_r    <= S_DONE;
                    end else begin
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    // A failed access retires as a bubble.
                    ctrl_regWrite_mem_wb  <= ctrl_regWrite_ex_mem & ~err_r;
                    ctrl_memToReg_mem_wb  <= ctrl_memToReg_ex_mem & ~err_r;
                    read_data_mem_wb      <= cap_data_r;
                    alu_result_mem_wb     <= alu_result_ex_mem;
                    write_register_mem_wb <= write_register_ex_mem;
                    err_r                 <= 1'b0;
                    state_r               <= S_IDLE;
                end
                default: begin
                    dmem_req <= 1'b0;
                    err_r    <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
